// File: rtl/soc_event_arbiter.sv
// soc_event_arbiter
// -----------------
// Turns rising edges of the sonar channel comparator flags into timestamped
// events and queues them for firmware. Each channel has a one-deep pending
// slot holding the timestamp of its latest unserved rise. A round-robin
// arbiter moves at most one pending slot per cycle into a show-ahead FIFO,
// and firmware drains that FIFO through the register file.
//
// Ports
//   wb_clk_i     system clock
//   wb_rst_ni    synchronous reset, active-low
//   ce_pcm       PCM-rate enable, advances the timestamp counter
//   mclear       synchronous soft clear (cmp history keeps sampling)
//   enable_i     per-channel capture enable mask
//   cmp_i        channel comparator flags (level)
//   pop_i        one-cycle strobe, removes the FIFO head
//   evt_valid_o  FIFO non-empty
//   evt_data_o   head event {channel index, timestamp}, 0 when empty
//   evt_count_o  FIFO occupancy
//   overflow_o   sticky: a rise arrived while its channel was still pending
//   irq_o        evt_valid_o | overflow_o
module soc_event_arbiter #(
    parameter int N_CH  = 15,
    parameter int ID_W  = 4,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      ce_pcm,
    input  logic                      mclear,
    input  logic [N_CH-1:0]           enable_i,
    input  logic [N_CH-1:0]           cmp_i,
    input  logic                      pop_i,
    output logic                      evt_valid_o,
    output logic [ID_W+TS_W-1:0]      evt_data_o,
    output logic [$clog2(DEPTH):0]    evt_count_o,
    output logic                      overflow_o,
    output logic                      irq_o
);

    localparam int EVT_W = ID_W + TS_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [N_CH-1:0]  cmp_q;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  rise;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  ts_lat_q [N_CH];
    logic [TS_W-1:0]  ts_lat_d [N_CH];
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [EVT_W-1:0] fifo_q [DEPTH];

    logic             found;
    logic             grant;
    logic             pop_eff;
    logic [ID_W-1:0]  winner;
    logic [EVT_W-1:0] push_data;

    assign rise    = cmp_i & ~cmp_q & enable_i;
    assign pop_eff = pop_i && (count_q != '0);

    // Round-robin scan starting at rr_ptr; the index sum is one bit wider so
    // the wrap at N_CH is exact even when N_CH is not a power of two.
    always_comb begin : arb_scan
        logic [ID_W:0]   idx_sum;
        logic [ID_W-1:0] idx;
        found   = 1'b0;
        winner  = '0;
        idx_sum = '0;
        idx     = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_sum >= (ID_W+1)'(N_CH)) begin
                idx_sum = idx_sum - (ID_W+1)'(N_CH);
            end
            idx = idx_sum[ID_W-1:0];
            if (!found && pending_q[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // A full FIFO still accepts a grant when the head leaves in the same cycle.
    assign grant     = found && ((count_q != CNT_W'(DEPTH)) || pop_i);
    assign push_data = {winner, ts_lat_q[winner]};

    // Pending slots: the grant clears its slot first, so a rise on the
    // channel being granted re-arms it with a fresh timestamp instead of
    // being counted as a drop.
    always_comb begin
        pending_d  = pending_q;
        ts_lat_d   = ts_lat_q;
        overflow_d = overflow_q;
        if (grant) begin
            pending_d[winner] = 1'b0;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (rise[i]) begin
                if (!pending_d[i]) begin
                    pending_d[i] = 1'b1;
                    ts_lat_d[i]  = ts_q;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // Pointer, counter and timestamp next-state values.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ts_d     = ce_pcm ? ts_q + TS_W'(1) : ts_q;
        if (grant) begin
            rr_ptr_d = (winner == ID_W'(N_CH - 1)) ? '0 : winner + ID_W'(1);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({grant, pop_eff})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Reset and soft clear share one path; only reset forgets the cmp history
    // so a soft clear never fabricates rises from levels already high.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || mclear) begin
            cmp_q      <= wb_rst_ni ? cmp_i : '0;
            pending_q  <= '0;
            ts_q       <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ts_lat_q[i] <= '0;
            end
        end else begin
            cmp_q      <= cmp_i;
            pending_q  <= pending_d;
            ts_q       <= ts_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ts_lat_q   <= ts_lat_d;
        end
    end

    // FIFO storage needs no reset: its contents are masked while empty.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_ni && !mclear && grant) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    assign evt_valid_o = (count_q != '0);
    assign evt_data_o  = evt_valid_o ? fifo_q[rd_ptr_q] : '0;
    assign evt_count_o = count_q;
    assign overflow_o  = overflow_q;
    assign irq_o       = evt_valid_o | overflow_q;

endmodule

// File: tb/tb_soc_event_arbiter.sv
// tb_soc_event_arbiter
// --------------------
// Drives soc_event_arbiter with directed scenarios followed by randomized
// traffic. A queue-based reference model tracks the expected FIFO contents
// and flags; a compare process checks every output on each falling edge,
// and directed scenarios pin the model with hand-computed literals.
module tb_soc_event_arbiter;

    localparam int N_CH  = 15;
    localparam int ID_W  = 4;
    localparam int TS_W  = 16;
    localparam int DEPTH = 8;
    localparam int EVT_W = ID_W + TS_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rstN;
    logic             cePcm;
    logic             mClear;
    logic [N_CH-1:0]  enable;
    logic [N_CH-1:0]  cmp;
    logic             pop;
    logic             evtValid;
    logic [EVT_W-1:0] evtData;
    logic [CNT_W-1:0] evtCount;
    logic             overflow;
    logic             irq;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model state
    logic [EVT_W-1:0] mq[$];
    bit               mPend  [N_CH];
    logic [TS_W-1:0]  mTsLat [N_CH];
    logic [TS_W-1:0]  mTs;
    logic [N_CH-1:0]  mCmp;
    int               mRr;
    bit               mOverflow;
    bit               modelReady = 1'b0;

    soc_event_arbiter #(
        .N_CH(N_CH), .ID_W(ID_W), .TS_W(TS_W), .DEPTH(DEPTH)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rstN),
        .ce_pcm      (cePcm),
        .mclear      (mClear),
        .enable_i    (enable),
        .cmp_i       (cmp),
        .pop_i       (pop),
        .evt_valid_o (evtValid),
        .evt_data_o  (evtData),
        .evt_count_o (evtCount),
        .overflow_o  (overflow),
        .irq_o       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: one step per rising edge, written from the event rules
    // (grant from old state, pop/push on a queue, then capture new rises).
    always @(posedge clk) begin
        if (!rstN || mClear) begin
            mCmp = rstN ? cmp : '0;
            mq.delete();
            for (int i = 0; i < N_CH; i++) begin
                mPend[i]  = 1'b0;
                mTsLat[i] = '0;
            end
            mTs        = '0;
            mRr        = 0;
            mOverflow  = 1'b0;
            modelReady = 1'b1;
        end else begin
            int g;
            bit anyPend;
            g = -1;
            anyPend = 1'b0;
            for (int i = 0; i < N_CH; i++) anyPend |= mPend[i];
            if (anyPend && (mq.size() < DEPTH || pop)) begin
                for (int k = 0; k < N_CH; k++) begin
                    int idx;
                    idx = (mRr + k) % N_CH;
                    if (g < 0 && mPend[idx]) g = idx;
                end
            end
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back({ID_W'(g), mTsLat[g]});
                mPend[g] = 1'b0;
                mRr = (g + 1) % N_CH;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (cmp[i] && !mCmp[i] && enable[i]) begin
                    if (!mPend[i]) begin
                        mPend[i]  = 1'b1;
                        mTsLat[i] = mTs;
                    end else begin
                        mOverflow = 1'b1;
                    end
                end
            end
            mCmp = cmp;
            if (cePcm) mTs = mTs + TS_W'(1);
        end
    end

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("valid", evtValid, mq.size() != 0);
            checkOutput("count", evtCount, mq.size());
            checkOutput("overflow", overflow, mOverflow);
            checkOutput("irq", irq, (mq.size() != 0) || mOverflow);
            if (mq.size() != 0) checkOutput("data", evtData, mq[0]);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        cmp    = '0;
        pop    = 1'b0;
        mClear = 1'b0;
        rstN   = 1'b0;
        tick(1);
        rstN   = 1'b1;
        tick(1);
    endtask

    // One randomized cycle; popPct sets how eagerly firmware drains.
    task automatic applyStimulus(input int popPct);
        logic [N_CH-1:0] flip;
        flip = '0;
        for (int i = 0; i < N_CH; i++) flip[i] = ($urandom_range(0, 7) == 0);
        cmp    = cmp ^ flip;
        cePcm  = $urandom_range(0, 1) == 1;
        pop    = $urandom_range(0, 99) < popPct;
        mClear = $urandom_range(0, 299) == 0;
        rstN   = $urandom_range(0, 699) != 0;
        if ($urandom_range(0, 63) == 0) enable = N_CH'($urandom) | N_CH'($urandom);
        tick(1);
    endtask

    initial begin
        rstN   = 1'b0;
        cePcm  = 1'b0;
        mClear = 1'b0;
        enable = '0;
        cmp    = '0;
        pop    = 1'b0;
        tick(2);
        rstN = 1'b1;
        tick(1);

        // Idle after reset
        checkOutput("reset valid", evtValid, 0);
        checkOutput("reset data", evtData, 0);
        checkOutput("reset count", evtCount, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset irq", irq, 0);

        // Single event with timestamp 5
        enable = '1;
        cePcm  = 1'b1;
        tick(5);
        cePcm  = 1'b0;
        cmp[3] = 1'b1;
        tick(2);
        checkOutput("single valid", evtValid, 1);
        checkOutput("single data", evtData, 20'h30005);
        checkOutput("single count", evtCount, 1);
        checkOutput("single irq", irq, 1);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        checkOutput("single pop count", evtCount, 0);
        checkOutput("single pop irq", irq, 0);

        // Fairness from rr_ptr = 0
        doReset();
        cmp = 15'h4084;
        tick(4);
        checkOutput("fair count", evtCount, 3);
        for (int n = 0; n < 3; n++) begin
            int expCh [3] = '{2, 7, 14};
            checkOutput("fair order", evtData[EVT_W-1:TS_W], expCh[n]);
            pop = 1'b1;
            tick(1);
            pop = 1'b0;
        end
        cmp = 15'h0003;
        tick(2);
        checkOutput("fair wrap head", evtData[EVT_W-1:TS_W], 0);

        // Full FIFO, held pending, then drop
        doReset();
        cmp = 15'h7F01;
        tick(11);
        checkOutput("full count", evtCount, 8);
        cePcm = 1'b1;
        tick(3);
        cePcm  = 1'b0;
        cmp[5] = 1'b1;
        tick(2);
        checkOutput("full held count", evtCount, 8);
        checkOutput("full held overflow", overflow, 0);
        cmp[5] = 1'b0;
        cePcm  = 1'b1;
        tick(1);
        cePcm  = 1'b0;
        cmp[5] = 1'b1;
        tick(1);
        checkOutput("drop overflow", overflow, 1);
        checkOutput("drop irq", irq, 1);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        checkOutput("full pop+push count", evtCount, 8);
        pop = 1'b1;
        tick(7);
        pop = 1'b0;
        checkOutput("drop single left", evtCount, 1);
        checkOutput("drop first ts", evtData, 20'h50003);
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        checkOutput("drop sticky irq", irq, 1);

        // Masking and level hold
        doReset();
        enable    = '1;
        enable[9] = 1'b0;
        cmp[9]    = 1'b1;
        tick(3);
        checkOutput("mask count", evtCount, 0);
        cmp[1] = 1'b1;
        tick(100);
        checkOutput("level count", evtCount, 1);

        // Soft clear with queued and pending events
        doReset();
        enable = '1;
        cePcm  = 1'b1;
        cmp    = 15'h0155;
        tick(4);
        cePcm  = 1'b0;
        checkOutput("clear setup count", evtCount, 3);
        mClear = 1'b1;
        tick(1);
        mClear = 1'b0;
        checkOutput("clear count", evtCount, 0);
        checkOutput("clear overflow", overflow, 0);
        tick(2);
        checkOutput("clear no grant", evtCount, 0);
        cmp[10] = 1'b1;
        tick(2);
        checkOutput("clear ts zero", evtData, 20'hA0000);

        // Reset mid-burst
        cmp = 15'h2A6B;
        tick(3);
        rstN = 1'b0;
        tick(1);
        checkOutput("midreset valid", evtValid, 0);
        checkOutput("midreset data", evtData, 0);
        checkOutput("midreset count", evtCount, 0);
        checkOutput("midreset irq", irq, 0);
        rstN = 1'b1;
        cmp  = '0;
        tick(1);

        // Randomized traffic at varying drain rates
        enable = '1;
        for (int b = 0; b < 6; b++) begin
            int rates [6] = '{10, 50, 90, 0, 30, 70};
            for (int c = 0; c < 500; c++) applyStimulus(rates[b]);
        end
        rstN   = 1'b1;
        mClear = 1'b0;
        pop    = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
